// File: rtl/pe_vector_loader.sv
// Streaming front-end for the combinational FP32 dot-product PE: packs (P,Q) pairs
// into N-element vectors, waits out the PE settle time, then hands the result downstream.
//
// state  | meaning
// FILL   | accepting operand pairs into the vector buffers
// SETTLE | buffers frozen, waiting for the PE multiply/add chain to settle
// HOLD   | captured result presented on out_valid/out_data until taken
module pe_vector_loader #(
   parameter int N          = 2,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_p,
   input  logic [31:0]        in_q,
   input  logic               in_last,
   output logic [32*N-1:0]    pe_p,
   output logic [32*N-1:0]    pe_q,
   input  logic [31:0]        pe_r,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic               frame_err,
   output logic               busy,
   output logic [CNT_W-1:0]   done_cnt
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N - 1);
   localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC);

   typedef enum logic [1:0] {S_FILL, S_SETTLE, S_HOLD} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               frame_err_q, frame_err_d;
   logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
   logic [31:0]        buf_p_q [N];
   logic [31:0]        buf_q_q [N];
   logic               accept;

   assign in_ready  = (state_q == S_FILL) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign frame_err = frame_err_q;
   assign done_cnt  = done_cnt_q;
   assign busy      = (state_q != S_FILL) || (idx_q != '0);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      settle_d    = settle_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      frame_err_d = 1'b0;
      done_cnt_d  = done_cnt_q;
      case (state_q)
         S_FILL: begin
            if (accept) begin
               // A full vector completes the frame whatever in_last says.
               if (idx_q == IDX_LAST) begin
                  idx_d    = '0;
                  settle_d = SETTLE_LOAD;
                  state_d  = S_SETTLE;
               end else if (in_last) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_SETTLE: begin
            settle_d = settle_q - 1'b1;
            if (settle_q == SET_W'(1)) begin
               out_data_d  = pe_r;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               done_cnt_d  = done_cnt_q + 1'b1;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         idx_q       <= '0;
         settle_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         done_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         settle_q    <= settle_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   // Buffers only move on accepts, so the PE inputs stay frozen through SETTLE/HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            buf_p_q[i] <= '0;
            buf_q_q[i] <= '0;
         end
      end else if (accept) begin
         buf_p_q[idx_q] <= in_p;
         buf_q_q[idx_q] <= in_q;
      end
   end

   always_comb begin
      pe_p = '0;
      pe_q = '0;
      for (int i = 0; i < N; i++) begin
         pe_p[32*i +: 32] = buf_p_q[i];
         pe_q[32*i +: 32] = buf_q_q[i];
      end
   end

endmodule

// File: doc/pe_vector_loader.md
Name: pe_vector_loader

Overview:
- Streaming front-end for the combinational floating-point dot-product PE.
- Accepts (P,Q) IEEE-754 single-precision operand pairs one per handshake and assembles them into N-element vector buffers that drive the PE inputs.
- After the last element, waits a programmable settle interval for the deep combinational multiply/add chain, then captures the PE result R.
- Presents the captured result on a valid/ready output port.

Parameters:
- N, 2, vector length; must equal the PE's element count; N >= 1.
- SETTLE_CYC, 2, clock cycles allowed for PE combinational settling (multicycle path); must be >= 1.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  loader can accept a pair.
- in_p  input  32  FP32 element of vector P.
- in_q  input  32  FP32 element of vector Q.
- in_last  input  1  marks the final element of a vector frame.
- pe_p  output  32*N  buffered P vector to the PE; element i at bits [32i+31:32i].
- pe_q  output  32*N  buffered Q vector to the PE; same packing.
- pe_r  input  32  PE result R (combinational from pe_p/pe_q).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  captured FP32 result.
- frame_err  output  1  one-cycle pulse on a framing error.
- busy  output  1  high when state is not FILL or idx != 0.
- done_cnt  output  CNT_W  count of results handed off downstream; wraps.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=FILL, idx=0, settle counter=0.
  - All buffer entries = 32'h0.
  - out_valid=0, out_data=0, frame_err=0, done_cnt=0, busy=0.
  - in_ready=0 while rst is high.
  - Reset asserted mid-frame or mid-settle discards the partial frame and any pending result, with no output.
- State machine: FILL -> SETTLE -> HOLD -> FILL.
- FILL:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready at a rising edge: buffer[idx] <= {in_p,in_q}.
  - If idx==N-1: idx<=0, settle counter<=SETTLE_CYC, go to SETTLE. This is a complete frame regardless of in_last.
  - If idx<N-1 and in_last=1: frame error. frame_err pulses for one cycle, idx<=0, the frame is discarded (buffer contents are don't-care), and the state stays FILL.
  - Otherwise: idx<=idx+1.
  - in_last=0 on element N-1 is not an error.
- SETTLE:
  - in_ready=0; pe_p/pe_q held stable.
  - The settle counter decrements each cycle.
  - On the edge where the counter equals 1: out_data<=pe_r, out_valid<=1, go to HOLD.
- HOLD:
  - in_ready=0; out_valid=1 and out_data held stable until out_ready=1.
  - On out_valid && out_ready: out_valid<=0, done_cnt<=done_cnt+1 (wraps 2^CNT_W-1 -> 0), go to FILL.
  - in_ready rises the cycle after the handoff; an input accept never coincides with an output handoff.
- Latency: last element accepted at edge k => out_valid is high after edge k+SETTLE_CYC.
- Throughput: one result per N + SETTLE_CYC + 1 cycles when out_ready is held high.
- pe_p/pe_q change only on FILL accepts. pe_r is sampled only at the capture edge; a timing constraint covers the SETTLE_CYC-cycle path.
- No FP interpretation is performed; operands are passed bit-exact, with no NaN or zero checking.
- N=1: every accepted pair completes a frame; in_last is never an error.

Test Plan:
- Basic dot product. N=2, PE initial value 10.0 (0x41200000). Send P={0x3F800000,0x40000000}, Q={0x40400000,0x40800000} (1,2 / 3,4), out_ready=1.
  -> out_valid rises 2 cycles after the second accept; out_data=0x41A80000 (21.0); done_cnt=1.
- Backpressure. Same frame with out_ready=0 for 5 cycles after out_valid.
  -> out_data stays 0x41A80000, in_ready=0 throughout, a single handoff on out_ready, done_cnt increments once.
- Early in_last. N=2; first pair sent with in_last=1.
  -> frame_err is a one-cycle pulse, no out_valid, idx back to 0. The next valid 2-element frame produces the correct result.
- Reset mid-SETTLE. Assert rst one cycle after the final accept.
  -> out_valid never rises, pe_p/pe_q=0, done_cnt=0. After release a new frame completes normally.
- Stall/gaps and counter wrap. Toggle in_valid randomly within a frame.
  -> only handshaken pairs are stored, in order (check pe_p/pe_q packing). Preload done_cnt via 65536 frames (or force) and check wrap to 0.
